// File: rtl/priority_pkg.sv
// ---------------------------------------------------------------------------
// priority_pkg
// Shared types for the priority decoder stream and its combinational base.
//   decode_mode_t : output style of the decoder (one-hot / thermometer masks)
//   skid_state_t  : occupancy of the output register + skid register pair
// ---------------------------------------------------------------------------
package priority_pkg;

   typedef enum logic [1:0] {
      DEC_ONEHOT    = 2'd0,
      DEC_THERM_INC = 2'd1,
      DEC_THERM_EXC = 2'd2
   } decode_mode_t;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } skid_state_t;

endpackage

// File: rtl/priority_decoder_stream_if.sv
// ---------------------------------------------------------------------------
// priority_decoder_stream_if
// Handshake bundle for priority_decoder_stream.
//   in_vld/in_rdy    : input transfer handshake
//   enc_idx/enc_vld  : encoded index payload (enc_vld=0 means "no bit set")
//   out_vld/out_rdy  : output transfer handshake
//   dec_vld          : decoded WIDTH-bit vector
//   err              : sticky out-of-range index flag
// Modports: master = producer/consumer side, slave = the decoder.
// ---------------------------------------------------------------------------
interface priority_decoder_stream_if #(
   parameter int WIDTH = 32
);
   localparam int WIDTH_LOG = $clog2(WIDTH);

   logic                 in_vld;
   logic                 in_rdy;
   logic [WIDTH_LOG-1:0] enc_idx;
   logic                 enc_vld;
   logic                 out_vld;
   logic                 out_rdy;
   logic [WIDTH-1:0]     dec_vld;
   logic                 err;

   modport master (
      output in_vld, enc_idx, enc_vld, out_rdy,
      input  in_rdy, out_vld, dec_vld, err
   );

   modport slave (
      input  in_vld, enc_idx, enc_vld, out_rdy,
      output in_rdy, out_vld, dec_vld, err
   );

endinterface

// File: rtl/priority_decoder_base.sv
// ---------------------------------------------------------------------------
// priority_decoder_base
// Purely combinational index -> vector decoder, counterpart of the encoder
// base. Usable standalone.
//   enc_idx_i : encoded index
//   enc_vld_i : index valid (0 -> all-zero output)
//   dec_vld_o : decoded vector, style chosen by MODE
//                 0 one-hot, 1 bits >= idx, 2 bits > idx
//   err_idx_o : enc_vld_i=1 with an index that has no bit position
// ---------------------------------------------------------------------------
module priority_decoder_base
   import priority_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MODE      = 0,
   localparam int WIDTH_LOG = $clog2(WIDTH)
) (
   input  logic [WIDTH_LOG-1:0] enc_idx_i,
   input  logic                 enc_vld_i,
   output logic [WIDTH-1:0]     dec_vld_o,
   output logic                 err_idx_o
);

   logic [31:0] idx_w;

   assign idx_w = 32'(enc_idx_i);

   always_comb begin
      dec_vld_o = '0;
      err_idx_o = 1'b0;
      if (enc_vld_i) begin
         // Only reachable when WIDTH is not a power of two.
         if (idx_w >= 32'(WIDTH)) begin
            err_idx_o = 1'b1;
         end else begin
            for (int i = 0; i < WIDTH; i++) begin
               case (MODE)
                  int'(DEC_ONEHOT):    dec_vld_o[i] = (32'(i) == idx_w);
                  int'(DEC_THERM_INC): dec_vld_o[i] = (32'(i) >= idx_w);
                  int'(DEC_THERM_EXC): dec_vld_o[i] = (32'(i) >  idx_w);
                  default:             dec_vld_o[i] = 1'b0;
               endcase
            end
         end
      end
   end

endmodule

// File: rtl/priority_decoder_stream.sv
// ---------------------------------------------------------------------------
// priority_decoder_stream
// Streaming wrapper around priority_decoder_base: decodes each accepted
// index into a WIDTH-bit vector with one cycle of latency, behind a
// two-entry (output register + skid register) buffer so in_rdy can be a
// flop while still sustaining one transfer per cycle.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : priority_decoder_stream_if.slave
//         in_vld/in_rdy/enc_idx/enc_vld in, out_vld/out_rdy/dec_vld out,
//         err sticky until reset
// ---------------------------------------------------------------------------
module priority_decoder_stream
   import priority_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int MODE  = 0
) (
   input logic                         clk,
   input logic                         rst,
   priority_decoder_stream_if.slave    bus
);

   skid_state_t       state_q, state_d;
   logic [WIDTH-1:0]  out_q, out_d;
   logic [WIDTH-1:0]  skid_q, skid_d;
   logic              in_rdy_q;
   logic              err_q, err_d;

   logic [WIDTH-1:0]  dec_w;
   logic              err_idx_w;
   logic              in_xfer;
   logic              out_xfer;

   priority_decoder_base #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
   ) u_base (
      .enc_idx_i (bus.enc_idx),
      .enc_vld_i (bus.enc_vld),
      .dec_vld_o (dec_w),
      .err_idx_o (err_idx_w)
   );

   assign in_xfer  = bus.in_vld & in_rdy_q;
   assign out_xfer = (state_q != EMPTY) & bus.out_rdy;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      err_d   = err_q | (in_xfer & err_idx_w);
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d = ONE;
               out_d   = dec_w;
            end
         end
         ONE: begin
            case ({in_xfer, out_xfer})
               2'b10: begin
                  // Consumer stalled: park the new word behind the output.
                  state_d = FULL;
                  skid_d  = dec_w;
               end
               2'b11:   out_d   = dec_w;
               2'b01:   state_d = EMPTY;
               default: ;
            endcase
         end
         FULL: begin
            // in_rdy is low here, so only the output side can move.
            if (out_xfer) begin
               state_d = ONE;
               out_d   = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EMPTY;
         out_q    <= '0;
         in_rdy_q <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         // Registered ready: no combinational path from out_rdy.
         in_rdy_q <= (state_d != FULL);
         err_q    <= err_d;
      end
   end

   // Skid contents are only meaningful in FULL, so no reset is needed.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

   assign bus.in_rdy  = in_rdy_q;
   assign bus.out_vld = (state_q != EMPTY);
   assign bus.dec_vld = out_q;
   assign bus.err     = err_q;

   a_idx_known : assert property (@(posedge clk) disable iff (rst)
      bus.in_vld |-> !$isunknown({bus.enc_idx, bus.enc_vld}));

   a_in_stable : assert property (@(posedge clk) disable iff (rst)
      (bus.in_vld && !bus.in_rdy) |=>
         (bus.in_vld && $stable(bus.enc_idx) && $stable(bus.enc_vld)));

   a_out_hold : assert property (@(posedge clk) disable iff (rst)
      (bus.out_vld && !bus.out_rdy) |=> (bus.out_vld && $stable(bus.dec_vld)));

endmodule

// File: tb/tb_priority_decoder_stream.sv
// ---------------------------------------------------------------------------
// tb_priority_decoder_stream
// Four decoders (W8 one-hot, W8 inclusive, W8 exclusive, W6 one-hot) share
// one stimulus stream. Expected vectors are queued on every input transfer
// and the head is compared whenever the queue says out_vld should be high.
// Queue depth also gives the expected in_rdy/out_vld.
// ---------------------------------------------------------------------------
module tb_priority_decoder_stream;

   typedef struct {
      logic [7:0] e0;
      logic [7:0] e1;
      logic [7:0] e2;
      logic [5:0] e3;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_vld, s_ev, s_ordy;
   logic [2:0] s_idx;
   bit         chk_en = 1'b0;
   bit         err3_exp = 1'b0;
   int         n_cmp = 0;
   int         n_mis = 0;
   exp_t       q[$];

   always #5 clk = ~clk;

   priority_decoder_stream_if #(.WIDTH(8)) i0 ();
   priority_decoder_stream_if #(.WIDTH(8)) i1 ();
   priority_decoder_stream_if #(.WIDTH(8)) i2 ();
   priority_decoder_stream_if #(.WIDTH(6)) i3 ();

   assign i0.in_vld = s_vld;  assign i0.enc_idx = s_idx;  assign i0.enc_vld = s_ev;  assign i0.out_rdy = s_ordy;
   assign i1.in_vld = s_vld;  assign i1.enc_idx = s_idx;  assign i1.enc_vld = s_ev;  assign i1.out_rdy = s_ordy;
   assign i2.in_vld = s_vld;  assign i2.enc_idx = s_idx;  assign i2.enc_vld = s_ev;  assign i2.out_rdy = s_ordy;
   assign i3.in_vld = s_vld;  assign i3.enc_idx = s_idx;  assign i3.enc_vld = s_ev;  assign i3.out_rdy = s_ordy;

   priority_decoder_stream #(.WIDTH(8), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
   priority_decoder_stream #(.WIDTH(8), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
   priority_decoder_stream #(.WIDTH(8), .MODE(2)) u2 (.clk(clk), .rst(rst), .bus(i2.slave));
   priority_decoder_stream #(.WIDTH(6), .MODE(0)) u3 (.clk(clk), .rst(rst), .bus(i3.slave));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_dec(int w, int mode, int idx, logic ev);
      logic [31:0] r = '0;
      if (ev && idx < w)
         for (int i = 0; i < w; i++)
            r[i] = (mode == 0) ? (i == idx) : (mode == 1) ? (i >= idx) : (i > idx);
      return r;
   endfunction

   function automatic exp_t make_exp(logic [2:0] idx, logic ev);
      exp_t e;
      e.e0 = 8'(ref_dec(8, 0, int'(idx), ev));
      e.e1 = 8'(ref_dec(8, 1, int'(idx), ev));
      e.e2 = 8'(ref_dec(8, 2, int'(idx), ev));
      e.e3 = 6'(ref_dec(6, 0, int'(idx), ev));
      return e;
   endfunction

   // Reference model: two-entry FIFO, updated on the same edge as the DUT.
   always @(posedge clk) begin
      bit acc, pop;
      if (rst) begin
         q.delete();
         err3_exp = 1'b0;
      end else begin
         acc = s_vld && (q.size() < 2);
         pop = s_ordy && (q.size() > 0);
         if (pop) void'(q.pop_front());
         if (acc) begin
            q.push_back(make_exp(s_idx, s_ev));
            if (s_ev && s_idx >= 3'd6) err3_exp = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      bit r, v;
      if (chk_en) begin
         r = (q.size() < 2);
         v = (q.size() > 0);
         chk("in_rdy",  {28'd0, i0.in_rdy, i1.in_rdy, i2.in_rdy, i3.in_rdy}, {28'd0, {4{r}}});
         chk("out_vld", {28'd0, i0.out_vld, i1.out_vld, i2.out_vld, i3.out_vld}, {28'd0, {4{v}}});
         chk("err",     {28'd0, i0.err, i1.err, i2.err, i3.err}, {31'd0, err3_exp});
         if (v) begin
            chk("dec_w8_onehot", 32'(i0.dec_vld), 32'(q[0].e0));
            chk("dec_w8_inc",    32'(i1.dec_vld), 32'(q[0].e1));
            chk("dec_w8_exc",    32'(i2.dec_vld), 32'(q[0].e2));
            chk("dec_w6_onehot", 32'(i3.dec_vld), 32'(q[0].e3));
         end
      end
   end

   task automatic send(input logic [2:0] idx, input logic ev, input bit rnd);
      int n = 0;
      bit r;
      s_vld = 1'b1;
      s_idx = idx;
      s_ev  = ev;
      forever begin
         if (rnd) s_ordy = 1'($urandom_range(0, 1));
         r = i0.in_rdy;
         @(negedge clk);
         if (r) break;
         n++;
         if (n > 50) begin
            chk("send_timeout", 32'(n), 32'd0);
            break;
         end
      end
      s_vld = 1'b0;
   endtask

   task automatic idle(input int n, input bit rnd);
      repeat (n) begin
         if (rnd) s_ordy = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk(tag, {i0.dec_vld, i1.dec_vld, i2.dec_vld, i3.dec_vld}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; s_vld = 1'b0; s_idx = '0; s_ev = 1'b0; s_ordy = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      chk_reset_state("reset_dec");

      // single transfer, then back-to-back
      send(3'd3, 1'b1, 1'b0);
      idle(1, 1'b0);
      send(3'd0, 1'b1, 1'b0);
      send(3'd7, 1'b1, 1'b0);
      send(3'd5, 1'b1, 1'b0);
      idle(2, 1'b0);

      // backpressure fills both entries, then drains in order
      s_ordy = 1'b0;
      send(3'd1, 1'b1, 1'b0);
      send(3'd2, 1'b1, 1'b0);
      idle(2, 1'b0);
      s_ordy = 1'b1;
      idle(3, 1'b0);

      // mode patterns, enc_vld=0, W6 out-of-range and sticky err
      send(3'd5, 1'b1, 1'b0);
      send(3'd7, 1'b1, 1'b0);
      send(3'd3, 1'b0, 1'b0);
      send(3'd6, 1'b1, 1'b0);
      send(3'd2, 1'b1, 1'b0);
      send(3'd7, 1'b1, 1'b0);
      idle(2, 1'b0);

      // reset while FULL with a coincident input offer
      s_ordy = 1'b0;
      send(3'd1, 1'b1, 1'b0);
      send(3'd2, 1'b1, 1'b0);
      rst = 1'b1; s_vld = 1'b1; s_idx = 3'd3; s_ev = 1'b1;
      @(negedge clk);
      rst = 1'b0; s_vld = 1'b0;
      chk_reset_state("midrst_dec");
      s_ordy = 1'b1;
      send(3'd4, 1'b1, 1'b0);
      idle(2, 1'b0);

      // random traffic with random backpressure
      for (int k = 0; k < 150; k++) begin
         send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0), 1'b1);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1'b1);
      end
      s_ordy = 1'b1;
      idle(4, 1'b0);
      chk("drain", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/priority_decoder_stream.md
Name: priority_decoder_stream

Overview:
- Inverse of the priority encoder: converts a stream of encoded indices (`enc_idx` plus `enc_vld`) back into a WIDTH-bit decoded vector (`dec_vld`).
- Output is one-hot, or an inclusive/exclusive thermometer mask for iterative "clear-found-bit and search again" loops.
- Sits downstream of the encoder (or an arbiter) in streaming datapaths.
- Valid/ready handshake on both sides; a 2-entry output skid buffer gives full throughput with registered `in_rdy`.

Parameters:
- WIDTH, 32, decoded vector width; any value ≥ 2 (power of two not required).
- WIDTH_LOG, $clog2(WIDTH), localparam: index width.
- MODE, 0, decode style: 0 one-hot; 1 thermometer with bits i ≥ idx set; 2 thermometer with bits i > idx set.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_vld  input  1  input transfer valid.
- in_rdy  output  1  input transfer ready (registered).
- enc_idx  input  WIDTH_LOG  encoded index.
- enc_vld  input  1  index valid; 0 means "no bit set".
- out_vld  output  1  output transfer valid.
- out_rdy  input  1  output transfer ready.
- dec_vld  output  WIDTH  decoded vector (registered).
- err  output  1  sticky flag: an index ≥ WIDTH was accepted with enc_vld=1.

Behaviour:
- Transfers:
  - Input transfer occurs when in_vld & in_rdy.
  - Output transfer occurs when out_vld & out_rdy.
  - in_vld must hold with stable payload until accepted.
  - Once asserted, out_vld holds with stable dec_vld until accepted.
- Decode function (combinational, applied before registering):
  - enc_vld=0 → all zeros, in every MODE.
  - enc_vld=1, idx < WIDTH:
    - MODE0: bit idx only.
    - MODE1: bits [WIDTH-1:idx].
    - MODE2: bits [WIDTH-1:idx+1]; all zeros when idx = WIDTH-1.
  - enc_vld=1, idx ≥ WIDTH: all zeros, and err set on the next edge.
- Latency: 1 cycle. Data accepted at edge N appears on dec_vld/out_vld after edge N.
- Throughput: 1 transfer/cycle while out_rdy=1.
- State machine (output register + skid register):
  - EMPTY: out_vld=0, in_rdy=1. Input transfer → ONE.
  - ONE: out_vld=1, in_rdy=1.
    - Input transfer with no output transfer → FULL (new data into skid).
    - Input and output transfer together → ONE (new data into output register).
    - Output transfer only → EMPTY.
  - FULL: out_vld=1, in_rdy=0. Output transfer → ONE (skid moves to output register, same edge).
- in_rdy is a flop equal to (next state ≠ FULL). No combinational path from out_rdy to in_rdy.
- Ordering is strictly FIFO; no transfer is dropped or duplicated.
- Reset, at a clk edge with rst=1:
  - State → EMPTY, out_vld=0, err=0, in_rdy=1.
  - dec_vld → all zeros.
  - Skid contents are don't-care.
  - Any input or output transfer coincident with rst is discarded.
  - Reset mid-operation flushes both entries.
- err is sticky until reset and does not affect the handshake.
- Simulation: X on enc_idx while in_vld=1 is an assertion failure. Assertions also cover payload stability under backpressure and out_vld never dropping without a transfer.

Decomposition:
- Shared package priority_pkg:
  - enum decode_mode_t {DEC_ONEHOT=0, DEC_THERM_INC=1, DEC_THERM_EXC=2}.
  - enum skid_state_t {EMPTY, ONE, FULL}.
- Sub-module priority_decoder_base: purely combinational decode with parameters WIDTH and MODE; enc_idx/enc_vld in, dec_vld/err_idx out. It is reused standalone and mirrors the encoder base.
- Top-level: skid FSM, registers and err flag.

Test Plan (WIDTH=8, MODE=0 unless stated):
- Reset, then enc_idx=3/enc_vld=1 with out_rdy=1 → next cycle out_vld=1, dec_vld=8'b0000_1000; in_rdy stays 1.
- Back-to-back idx 0,7,5 with out_rdy=1 → outputs 8'h01, 8'h80, 8'h20 on consecutive cycles, no gaps.
- out_rdy=0, send idx 1 then idx 2 → in_rdy=0 after second accept, dec_vld holds 8'h02. Raise out_rdy → 8'h02, then 8'h04, and in_rdy returns to 1.
- MODE=1 idx=5 → 8'b1110_0000. MODE=2 idx=5 → 8'b1100_0000. MODE=2 idx=7 → 8'h00. enc_vld=0 in any MODE → 8'h00.
- WIDTH=6, idx=6, enc_vld=1 → dec_vld=6'b0, err=1. err stays 1 after further valid indices until rst.
- In FULL state, assert rst for one cycle → out_vld=0, in_rdy=1, err=0. A subsequent idx=4 yields 8'h10 with 1-cycle latency.
